// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller:
// FSM encoding, config addresses, register bit positions.
package intr_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK  = 2'd0;
    localparam logic [1:0] ADDR_PEND  = 2'd1;
    localparam logic [1:0] ADDR_EPC   = 2'd2;
    localparam logic [1:0] ADDR_CAUSE = 2'd3;

    localparam int CAUSE_SVC = 31;
    localparam int CAUSE_REQ = 30;
    localparam int IE_BIT    = 31;

    // Bit 0 has the highest priority.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = '0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) lowest_idx = 3'(i);
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-side bundle of the interrupt controller:
// config port plus trap handshake.
interface intr_ctrl_if;

    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        int_req;
    logic [31:0] int_vector;
    logic        int_ack;
    logic [31:0] ack_pc;
    logic        eret;
    logic        in_service;
    logic [31:0] epc;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        output int_ack, ack_pc, eret,
        input  cfg_rdata, int_req, int_vector,
        input  in_service, epc
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        input  int_ack, ack_pc, eret,
        output cfg_rdata, int_req, int_vector,
        output in_service, epc
    );

endinterface

// File: rtl/intr_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector;
// emits a one-cycle pulse per synchronised rising edge.
module intr_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic s1, s2, prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign pulse = s2 & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched pending sources, masking,
// fixed-priority trap request, EPC capture and ERET handling.
module intr_ctrl
    import intr_defs::*;
#(
    parameter int          NUM_SRC    = 2,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0008,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] SW_INT,
    intr_ctrl_if.slave         bus
);

    localparam logic [31:0] MASK_RW =
        32'h8000_0000 | 32'((64'd1 << NUM_SRC) - 64'd1);

    logic [NUM_SRC-1:0] edge_p;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] mask_en;
    logic [NUM_SRC-1:0] sel;
    logic [31:0]        mask_q;
    logic               ie;
    logic [7:0]         act;

    state_t      state, state_n;
    logic        req_q, req_n;
    logic        svc_q, svc_n;
    logic [31:0] vec_q, vec_n;
    logic [31:0] epc_q, epc_n;
    logic [2:0]  id_q, id_n;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        intr_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (SW_INT[g]),
            .pulse (edge_p[g])
        );
    end

    wire cfg_mask = bus.cfg_we && (bus.cfg_addr == ADDR_MASK);
    wire cfg_pend = bus.cfg_we && (bus.cfg_addr == ADDR_PEND);
    wire take_ack = (state == REQ) && bus.int_ack;

    assign mask_en = mask_q[NUM_SRC-1:0];
    assign ie      = mask_q[IE_BIT];
    assign act     = 8'(pend & mask_en);
    assign sel     = NUM_SRC'(1) << id_q;

    always_comb begin
        pend_clr = '0;
        if (cfg_pend)
            pend_clr = bus.cfg_wdata[NUM_SRC-1:0];
        if (take_ack)
            pend_clr = pend_clr | sel;
    end

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            pend   <= '0;
        end else begin
            if (cfg_mask)
                mask_q <= bus.cfg_wdata & MASK_RW;
            pend <= (pend & ~pend_clr) | edge_p;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = req_q;
        svc_n   = svc_q;
        vec_n   = vec_q;
        epc_n   = epc_q;
        id_n    = id_q;
        unique case (state)
            IDLE: begin
                if (ie && (act != 8'd0)) begin
                    id_n    = lowest_idx(act);
                    vec_n   = VEC_BASE
                            + 32'(id_n) * 32'(VEC_STRIDE);
                    req_n   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    epc_n   = bus.ack_pc;
                    req_n   = 1'b0;
                    svc_n   = 1'b1;
                    state_n = SERVICE;
                end else if (!ie || ((mask_en & sel) == '0)
                             || ((pend & sel) == '0)) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            SERVICE: begin
                if (bus.eret) begin
                    svc_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                svc_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            req_q <= 1'b0;
            svc_q <= 1'b0;
            vec_q <= VEC_BASE;
            epc_q <= '0;
            id_q  <= '0;
        end else begin
            state <= state_n;
            req_q <= req_n;
            svc_q <= svc_n;
            vec_q <= vec_n;
            epc_q <= epc_n;
            id_q  <= id_n;
        end
    end

    always_comb begin
        bus.cfg_rdata = '0;
        unique case (bus.cfg_addr)
            ADDR_MASK:  bus.cfg_rdata = mask_q;
            ADDR_PEND:  bus.cfg_rdata = 32'(pend);
            ADDR_EPC:   bus.cfg_rdata = epc_q;
            ADDR_CAUSE: begin
                bus.cfg_rdata[CAUSE_SVC] = svc_q;
                bus.cfg_rdata[CAUSE_REQ] = req_q;
                bus.cfg_rdata[2:0]       = id_q;
            end
        endcase
    end

    assign bus.int_req    = req_q;
    assign bus.int_vector = vec_q;
    assign bus.in_service = svc_q;
    assign bus.epc        = epc_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: expected handler vectors are queued
// at stimulus time and checked when int_req rises.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = '0;

    intr_ctrl_if ifc();

    intr_ctrl #(.NUM_SRC(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .SW_INT (sw),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic        req_prev = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifc.int_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_req: got vector %h want no request",
                         ifc.int_vector);
            end else begin
                chk("int_vector", ifc.int_vector, exp_q.pop_front());
            end
        end
        req_prev = ifc.int_req;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        ifc.cfg_we = 1'b1;
        ifc.cfg_addr = a;
        ifc.cfg_wdata = d;
        tick();
        ifc.cfg_we = 1'b0;
    endtask

    task automatic rd(logic [1:0] a, output logic [31:0] d);
        ifc.cfg_addr = a;
        #1 d = ifc.cfg_rdata;
    endtask

    task automatic rd_chk(string nm, logic [1:0] a, logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic wait_req();
        int k = 0;
        while (!ifc.int_req && k < 20) begin
            tick();
            k++;
        end
        chk("req_seen", 32'(ifc.int_req), 32'd1);
    endtask

    task automatic ack(logic [31:0] pc);
        ifc.int_ack = 1'b1;
        ifc.ack_pc = pc;
        tick();
        ifc.int_ack = 1'b0;
        chk("ack_epc", ifc.epc, pc);
        chk("ack_svc", 32'(ifc.in_service), 32'd1);
        chk("ack_req", 32'(ifc.int_req), 32'd0);
    endtask

    task automatic do_eret();
        ifc.eret = 1'b1;
        tick();
        ifc.eret = 1'b0;
        chk("eret_svc", 32'(ifc.in_service), 32'd0);
    endtask

    task automatic settle_low();
        sw = '0;
        tick(4);
    endtask

    initial begin
        logic [3:0] msk, rs, pm;
        logic [31:0] pc;
        ifc.cfg_we = 1'b0;
        ifc.cfg_addr = '0;
        ifc.cfg_wdata = '0;
        ifc.int_ack = 1'b0;
        ifc.ack_pc = '0;
        ifc.eret = 1'b0;
        tick(2);
        chk("rst_req", 32'(ifc.int_req), 32'd0);
        chk("rst_svc", 32'(ifc.in_service), 32'd0);
        chk("rst_vec", ifc.int_vector, 32'h8);
        chk("rst_epc", ifc.epc, 32'h0);
        rd_chk("rst_mask", 2'd0, 32'h0);
        rd_chk("rst_cause", 2'd3, 32'h0);
        reset = 1'b0;
        tick();

        // basic request / ack / eret on source 1
        wr(2'd0, 32'hFFFF_FFFF);
        rd_chk("mask_rw", 2'd0, 32'h8000_000F);
        wr(2'd0, 32'h8000_0003);
        sw[1] = 1'b1;
        exp_q.push_back(32'h10);
        tick(3);
        chk("req_before_e3", 32'(ifc.int_req), 32'd0);
        tick();
        chk("req_at_e3", 32'(ifc.int_req), 32'd1);
        rd_chk("cause_req", 2'd3, 32'h4000_0001);
        ack(32'h40);
        rd_chk("pend_after_ack", 2'd1, 32'h0);
        rd_chk("epc_read", 2'd2, 32'h40);
        rd_chk("cause_svc", 2'd3, 32'h8000_0001);
        wr(2'd2, 32'h1234);
        rd_chk("epc_ro", 2'd2, 32'h40);
        do_eret();
        tick(2);
        chk("idle_no_req", 32'(ifc.int_req), 32'd0);
        settle_low();

        // simultaneous sources: priority order
        sw = 4'b0011;
        exp_q.push_back(32'h08);
        exp_q.push_back(32'h10);
        wait_req();
        ack(32'h100);
        do_eret();
        wait_req();
        ack(32'h104);
        do_eret();
        settle_low();

        // global IE gating and withdraw on mask clear
        wr(2'd0, 32'h0000_0003);
        sw[0] = 1'b1;
        tick(5);
        chk("ie_off_req", 32'(ifc.int_req), 32'd0);
        rd_chk("ie_off_pend", 2'd1, 32'h1);
        exp_q.push_back(32'h08);
        wr(2'd0, 32'h8000_0003);
        chk("ie_on_lat0", 32'(ifc.int_req), 32'd0);
        tick();
        chk("ie_on_req", 32'(ifc.int_req), 32'd1);
        wr(2'd0, 32'h8000_0002);
        tick();
        chk("withdraw_req", 32'(ifc.int_req), 32'd0);
        rd_chk("withdraw_pend", 2'd1, 32'h1);
        wr(2'd1, 32'hF);
        settle_low();

        // no nesting while in service
        wr(2'd0, 32'h8000_0003);
        sw[1] = 1'b1;
        exp_q.push_back(32'h10);
        wait_req();
        ack(32'h200);
        sw[0] = 1'b1;
        tick(5);
        chk("svc_no_req", 32'(ifc.int_req), 32'd0);
        rd_chk("svc_pend", 2'd1, 32'h1);
        exp_q.push_back(32'h08);
        do_eret();
        chk("eret_req0", 32'(ifc.int_req), 32'd0);
        tick();
        chk("eret_req1", 32'(ifc.int_req), 32'd1);
        ack(32'h204);
        do_eret();
        settle_low();

        // W1C coincident with a new edge; ack beats withdraw
        wr(2'd0, 32'h0);
        sw[0] = 1'b1;
        tick(4);
        rd_chk("pend_nomask", 2'd1, 32'h1);
        sw = '0;
        tick(4);
        sw[0] = 1'b1;
        tick(2);
        wr(2'd1, 32'h1);
        rd_chk("w1c_vs_edge", 2'd1, 32'h1);
        wr(2'd1, 32'h1);
        rd_chk("w1c_plain", 2'd1, 32'h0);
        settle_low();
        wr(2'd0, 32'h8000_0001);
        sw[0] = 1'b1;
        exp_q.push_back(32'h08);
        wait_req();
        ifc.int_ack = 1'b1;
        ifc.ack_pc = 32'h300;
        ifc.cfg_we = 1'b1;
        ifc.cfg_addr = 2'd0;
        ifc.cfg_wdata = 32'h0;
        ifc.eret = 1'b1;
        tick();
        ifc.int_ack = 1'b0;
        ifc.cfg_we = 1'b0;
        ifc.eret = 1'b0;
        chk("ackwin_svc", 32'(ifc.in_service), 32'd1);
        chk("ackwin_epc", ifc.epc, 32'h300);
        rd_chk("ackwin_mask", 2'd0, 32'h0);
        do_eret();
        settle_low();
        wr(2'd1, 32'hF);

        // asynchronous reset in REQ and in SERVICE
        wr(2'd0, 32'h8000_0001);
        sw[0] = 1'b1;
        exp_q.push_back(32'h08);
        wait_req();
        #2 reset = 1'b1;
        #1;
        chk("arst_req_req", 32'(ifc.int_req), 32'd0);
        chk("arst_req_svc", 32'(ifc.in_service), 32'd0);
        rd_chk("arst_req_mask", 2'd0, 32'h0);
        tick();
        reset = 1'b0;
        settle_low();
        wr(2'd1, 32'hF);
        wr(2'd0, 32'h8000_0001);
        sw[0] = 1'b1;
        exp_q.push_back(32'h08);
        wait_req();
        ack(32'h400);
        #2 reset = 1'b1;
        #1;
        chk("arst_svc_svc", 32'(ifc.in_service), 32'd0);
        chk("arst_svc_epc", ifc.epc, 32'h0);
        chk("arst_svc_req", 32'(ifc.int_req), 32'd0);
        rd_chk("arst_svc_mask", 2'd0, 32'h0);
        tick();
        reset = 1'b0;
        settle_low();
        wr(2'd1, 32'hF);

        // randomized: service order is ascending index of raised & mask
        for (int it = 0; it < 24; it++) begin
            msk = 4'($urandom_range(1, 15));
            rs  = 4'($urandom_range(1, 15));
            pm  = rs;
            wr(2'd0, 32'h8000_0000 | 32'(msk));
            sw = rs;
            for (int i = 0; i < 4; i++)
                if (rs[i] && msk[i])
                    exp_q.push_back(32'h8 + 32'(i) * 32'd8);
            for (int i = 0; i < 4; i++) begin
                if (rs[i] && msk[i]) begin
                    wait_req();
                    pc = $urandom;
                    ack(pc);
                    pm[i] = 1'b0;
                    rd_chk("rnd_pend", 2'd1, 32'(pm));
                    do_eret();
                end
            end
            tick(3);
            chk("rnd_no_req", 32'(ifc.int_req), 32'd0);
            rd_chk("rnd_left", 2'd1, 32'(rs & ~msk));
            wr(2'd1, 32'hF);
            settle_low();
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller between the external interrupt sources (`SW_INT`) and the pipelined MIPS CPU core.
- Synchronises and edge-detects each source, then latches it as pending, masks it and selects one by fixed priority.
- Raises a single trap request with a handler vector to the pipeline, records the EPC when the pipeline accepts, and blocks further traps until `eret`.
- Also holds the CP0-style mask, pending, EPC and cause registers behind a small config port.

Parameters:
- NUM_SRC, 2, number of interrupt sources (1..8).
- VEC_BASE, 32'h0000_0008, handler address for source 0.
- VEC_STRIDE, 8, byte distance between consecutive source handlers.

Ports:
- clk  in  1  main clock.
- reset  in  1  asynchronous active-high reset.
- SW_INT  in  NUM_SRC  raw interrupt sources, asynchronous to clk, rising-edge triggered.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  config register select: 0 MASK, 1 PEND, 2 EPC, 3 CAUSE.
- cfg_wdata  in  32  config write data.
- cfg_rdata  out  32  config read data, combinational from cfg_addr.
- int_req  out  1  trap request to the pipeline.
- int_vector  out  32  handler address; valid while int_req=1.
- int_ack  in  1  pipeline has flushed and taken the trap this cycle.
- ack_pc  in  32  PC of the interrupted instruction; sampled on int_ack.
- eret  in  1  ERET has retired; the handler is finished.
- in_service  out  1  a handler is running.
- epc  out  32  saved return PC.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - MASK, PEND, EPC, latched id and synchroniser flops all clear to 0.
  - FSM goes to IDLE; int_req=0, in_service=0, int_vector=VEC_BASE.
- Per-source front end:
  - Two-flop synchroniser, then a rising-edge detector on the second flop (s2 & ~prev).
  - A source high before edge E0 sets PEND on edge E2. int_req rises at E3 at the earliest.
  - Pulses shorter than one clk period may be lost; this is accepted.
- MASK register:
  - Bits [NUM_SRC-1:0] are per-source enables; bit 31 is global IE. Other bits read 0.
  - Written by cfg_we with addr 0.
- PEND register:
  - Written with addr 1 as write-1-to-clear.
  - A new edge on a bit in the same cycle as a clear of that bit (W1C or ack) leaves the bit set: set wins.
- EPC and CAUSE are read-only through the config port; writes to addr 2 and 3 are ignored.
- CAUSE layout: bit31 in_service, bit30 int_req, bits[2:0] latched id; other bits 0.
- FSM, fully registered outputs:
  - IDLE:
    - When IE=1 and (PEND & MASK)≠0, latch id = lowest set index (bit 0 has highest priority).
    - Set int_vector = VEC_BASE + id*VEC_STRIDE (32-bit, wraps modulo 2^32).
    - Set int_req=1 and go to REQ.
  - REQ:
    - Hold int_req, id and int_vector stable; a later higher-priority source does not replace the latched id.
    - On int_ack: EPC<=ack_pc, clear PEND[id], int_req<=0, in_service<=1, go to SERVICE.
    - Otherwise, if IE or MASK[id] has been cleared, or PEND[id] has been W1C-cleared: withdraw int_req and return to IDLE.
    - int_ack in the same cycle as the withdrawing write: the ack wins.
  - SERVICE:
    - No nesting; further pending bits only accumulate.
    - On eret: in_service<=0, go to IDLE. Still-pending enabled sources re-request on the following cycle.
- Ignored inputs:
  - int_ack outside REQ.
  - eret outside SERVICE.
  - int_ack and eret together in REQ: only the ack is processed.
- Config writes are allowed in any state and take effect the next cycle.

Decomposition:
- Shared package `intr_defs`:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - cfg address constants: ADDR_MASK, ADDR_PEND, ADDR_EPC, ADDR_CAUSE.
  - CAUSE bit positions.
  - IE bit index (31).
- Sub-module `intr_sync_edge`, instantiated NUM_SRC times: two-flop synchroniser plus edge detect, async reset, one-cycle pulse output.

Test Plan:
1. Reset, write MASK=32'h8000_0003, raise SW_INT[1] -> int_req=1 three edges later, int_vector=32'h10; ack with ack_pc=32'h40 -> epc=32'h40, PEND=0, in_service=1; eret -> IDLE.
2. SW_INT=2'b11 rising on the same edge -> id 0 first with int_vector=32'h08; after eret, id 1 is requested with int_vector=32'h10.
3. IE=0 with pending source 0 -> no int_req and PEND reads 1; set IE=1 -> int_req next cycle; clear MASK[0] while in REQ -> int_req withdrawn and PEND stays 1.
4. In SERVICE, raise SW_INT[0] -> no int_req and PEND[0]=1; eret -> int_req asserted one cycle later.
5. W1C of PEND[0] coincident with a new synchronised edge on source 0 -> PEND[0] stays 1; int_ack and withdraw write in the same cycle -> SERVICE entered.
6. Assert reset asynchronously while in REQ and while in SERVICE -> int_req, in_service, epc and MASK are 0 immediately, without waiting for a clk edge.
